sample_mixer: RTL and testbench

Downstream stage of the three-voice chord player. On each codec request it collects one sample from every active note player, sums them with a configurable gain shift and saturation, and presents one 16-bit mixed sample with a single-cycle ready pulse to the codec interface. Missing voices are tolerated through a timeout, so a stalled player cannot block the audio stream.

---
 rtl/mixer_pkg.sv | 28 ++
 rtl/voice_capture.sv | 40 ++++
 rtl/sample_mixer.sv | 158 +++++++++++++++
 tb/tb_sample_mixer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// mixer_pkg
// Shared definitions for the chord-player sample mixer.
//   mix_state_t  : sequencing states of the mixer FSM
//   sum_width()  : width needed to add num_voices signed samples without overflow
//   sat_max()    : largest value representable in a signed word of the given width
//   sat_min()    : smallest value representable in a signed word of the given width
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2,
        OUTPUT  = 2'd3
    } mix_state_t;

    function automatic int sum_width(input int sample_width, input int num_voices);
        return sample_width + $clog2(num_voices);
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/voice_capture.sv
// voice_capture
// Holds the most recent sample taken from one note player for the mix in
// progress, together with a flag saying whether that voice has delivered.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : start of a new mix; forgets the previous capture
//   enable     : take 'sample' this cycle (may coincide with clear)
//   sample     : signed sample from the player
//   data       : captured sample, zero when nothing was captured
//   captured   : high once a sample has been taken for this mix
module voice_capture
    import mixer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] data,
    output logic             captured
);

    // A ready pulse in the request cycle itself must survive the clear,
    // so clear and enable are resolved together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data     <= '0;
            captured <= 1'b0;
        end else if (clear) begin
            captured <= enable;
            data     <= enable ? sample : '0;
        end else if (enable) begin
            captured <= 1'b1;
            data     <= sample;
        end
    end

endmodule

// File: rtl/sample_mixer.sv
// sample_mixer
// Collects one sample from every active note player per codec request,
// sums them, applies a gain shift and saturation, and presents the mixed
// sample with a one-cycle ready pulse. Stalled players are bounded by a
// timeout so the audio stream never blocks.
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   generate_next_sample : codec request pulse
//   voice_active         : bit k high when player k is still sounding
//   sample_in            : voice k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH], signed
//   sample_ready_in      : per-player new-sample pulses
//   sample_out           : mixed signed sample, held between updates
//   new_sample_ready     : one-cycle pulse when sample_out is fresh
//   voice_timeout        : pulses with new_sample_ready if a voice was missing
//   request_overrun      : pulses the cycle after a request arriving while busy
module sample_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES     = 3,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int GAIN_SHIFT     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               generate_next_sample,
    input  logic [NUM_VOICES-1:0]              voice_active,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
    input  logic [NUM_VOICES-1:0]              sample_ready_in,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               new_sample_ready,
    output logic                               voice_timeout,
    output logic                               request_overrun
);

    localparam int SUM_W = sum_width(SAMPLE_WIDTH, NUM_VOICES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(sat_max(SAMPLE_WIDTH));
    localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(sat_min(SAMPLE_WIDTH));
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    mix_state_t                         state;
    logic [NUM_VOICES-1:0]              expect_mask;
    logic [NUM_VOICES-1:0]              captured;
    logic [NUM_VOICES-1:0]              capture_en;
    logic                               capture_clear;
    logic                               request_accept;
    logic                               all_present;
    logic [CNT_W-1:0]                   timeout_cnt;
    logic                               timeout_armed;
    logic [SAMPLE_WIDTH-1:0]            voice_data [NUM_VOICES];
    logic signed [SUM_W-1:0]            raw_sum;
    logic signed [SUM_W-1:0]            shifted_sum;
    logic [SAMPLE_WIDTH-1:0]            mix_value;

    // Capture qualification. In the request cycle the mask is not yet
    // registered, so the live voice_active decides which readies count.
    always_comb begin
        request_accept = (state == IDLE) && generate_next_sample;
        capture_clear  = request_accept;
        if (request_accept) begin
            capture_en = sample_ready_in & voice_active;
        end else if (state == COLLECT) begin
            capture_en = sample_ready_in & expect_mask & ~captured;
        end else begin
            capture_en = '0;
        end
        // Same-cycle readies count as present, so a ready that coincides
        // with the timeout still completes the set.
        all_present = ((captured | capture_en) & expect_mask) == expect_mask;
    end

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
        voice_capture #(
            .WIDTH(SAMPLE_WIDTH)
        ) u_capture (
            .clk      (clk),
            .reset    (reset),
            .clear    (capture_clear),
            .enable   (capture_en[k]),
            .sample   (sample_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .data     (voice_data[k]),
            .captured (captured[k])
        );
    end

    // Adder tree, gain shift and saturation. Uncaptured voices add nothing.
    always_comb begin
        raw_sum = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (captured[k]) begin
                raw_sum = raw_sum + SUM_W'($signed(voice_data[k]));
            end
        end
        shifted_sum = raw_sum >>> GAIN_SHIFT;
        if (shifted_sum > SAT_HI) begin
            mix_value = SAT_HI[SAMPLE_WIDTH-1:0];
        end else if (shifted_sum < SAT_LO) begin
            mix_value = SAT_LO[SAMPLE_WIDTH-1:0];
        end else begin
            mix_value = shifted_sum[SAMPLE_WIDTH-1:0];
        end
    end

    // Sequencer with registered outputs. The ready/timeout pulses are set
    // on leaving SUM so they are high exactly during the OUTPUT cycle,
    // together with the freshly registered sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            expect_mask      <= '0;
            timeout_cnt      <= '0;
            timeout_armed    <= 1'b0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            voice_timeout    <= 1'b0;
            request_overrun  <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            voice_timeout    <= 1'b0;
            request_overrun  <= generate_next_sample && (state != IDLE);
            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        expect_mask   <= voice_active;
                        timeout_cnt   <= CNT_LOAD;
                        timeout_armed <= 1'b0;
                        state         <= (voice_active == '0) ? SUM : COLLECT;
                    end
                end
                COLLECT: begin
                    if (all_present) begin
                        state <= SUM;
                    end else if (timeout_cnt == '0) begin
                        state         <= SUM;
                        timeout_armed <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt - CNT_W'(1);
                    end
                end
                SUM: begin
                    sample_out       <= mix_value;
                    new_sample_ready <= 1'b1;
                    voice_timeout    <= timeout_armed;
                    state            <= OUTPUT;
                end
                OUTPUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_mixer.sv
// tb_sample_mixer
// Scoreboard bench for sample_mixer: each request pushes the expected mix,
// timeout flag and pulse cycle computed from a plain arithmetic model; an
// independent monitor pops and compares whenever the DUT pulses.
module tb_sample_mixer;

    localparam int NV = 3;
    localparam int SW = 16;
    localparam int GS = 1;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              gen = 1'b0;
    logic [NV-1:0]     active = '0;
    logic [NV-1:0]     ready = '0;
    logic [NV*SW-1:0]  sample_in = '0;
    logic [SW-1:0]     sample_out;
    logic              nsr;
    logic              vt;
    logic              ro;

    sample_mixer #(
        .NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .GAIN_SHIFT(GS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .generate_next_sample (gen),
        .voice_active         (active),
        .sample_in            (sample_in),
        .sample_ready_in      (ready),
        .sample_out           (sample_out),
        .new_sample_ready     (nsr),
        .voice_timeout        (vt),
        .request_overrun      (ro)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int value;
        int timeout;
        int cycle;
    } exp_t;

    exp_t sb_q[$];
    int   ov_q[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction description consumed by applyStimulus
    logic [NV-1:0] t_active;
    int            t_sample [NV];
    int            t_delay  [NV];
    int            t_extra;
    int            t_junk;
    bit            t_random_junk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportUnexpected(input string name, input int actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d, expected none (cycle %0d)", name, actual, cyc);
    endtask

    // Reference: which voices arrive inside the window, when the mix closes,
    // and the shifted/clamped sum.
    task automatic modelTransaction(output int pulse_rel, output int value, output int timed_out);
        int  sum;
        int  exit_rel;
        bit  missing;
        sum      = 0;
        exit_rel = 1;
        missing  = 1'b0;
        if (t_active == '0) begin
            pulse_rel = 2;
            value     = 0;
            timed_out = 0;
            return;
        end
        for (int k = 0; k < NV; k++) begin
            if (t_active[k]) begin
                if (t_delay[k] >= 0 && t_delay[k] <= TO) begin
                    sum += t_sample[k];
                    if (t_delay[k] > exit_rel) exit_rel = t_delay[k];
                end else begin
                    missing = 1'b1;
                end
            end
        end
        if (missing) exit_rel = TO;
        sum = sum >>> GS;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        pulse_rel = exit_rel + 2;
        value     = sum;
        timed_out = missing ? 1 : 0;
    endtask

    function automatic logic [SW-1:0] junkValue();
        logic [SW-1:0] v;
        v = t_random_junk ? SW'($urandom) : SW'(t_junk);
        return v;
    endfunction

    // Drives one request and its player traffic; must be entered just after
    // a rising edge. Expectations are pushed before the first edge.
    task automatic applyStimulus();
        int   pulse_rel;
        int   value;
        int   tmo;
        int   c0;
        exp_t e;
        modelTransaction(pulse_rel, value, tmo);
        if (t_extra >= pulse_rel) t_extra = pulse_rel - 1;
        c0        = cyc;
        e.value   = value;
        e.timeout = tmo;
        e.cycle   = c0 + pulse_rel;
        sb_q.push_back(e);
        if (t_extra > 0) ov_q.push_back(c0 + t_extra + 1);
        for (int c = 0; c < pulse_rel + 2; c++) begin
            gen    = (c == 0) || (c == t_extra);
            active = (c == 0) ? t_active : NV'($urandom);
            for (int k = 0; k < NV; k++) begin
                logic          r;
                logic [SW-1:0] v;
                r = 1'b0;
                v = junkValue();
                if (t_active[k]) begin
                    if (c == t_delay[k]) begin
                        r = 1'b1;
                        v = SW'(t_sample[k]);
                    end else if (t_delay[k] >= 0 && c > t_delay[k] && $urandom_range(3) == 0) begin
                        r = 1'b1;
                    end
                end else if (c == 3 || $urandom_range(3) == 0) begin
                    r = 1'b1;
                end
                ready[k]               = r;
                sample_in[k*SW +: SW]  = v;
            end
            @(posedge clk);
            #1;
        end
        gen   = 1'b0;
        ready = '0;
        checkOutput("pending_mixes", sb_q.size(), 0);
        checkOutput("pending_overruns", ov_q.size(), 0);
        sb_q.delete();
        ov_q.delete();
        t_extra = 0;
    endtask

    task automatic setVoices(input logic [NV-1:0] act, input int s0, input int s1, input int s2,
                             input int d0, input int d1, input int d2);
        t_active    = act;
        t_sample[0] = s0;
        t_sample[1] = s1;
        t_sample[2] = s2;
        t_delay[0]  = d0;
        t_delay[1]  = d1;
        t_delay[2]  = d2;
    endtask

    // Monitor: compares every pulse against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (nsr) begin
                if (sb_q.size() == 0) begin
                    reportUnexpected("unexpected_ready", int'($signed(sample_out)));
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sample_out", int'($signed(sample_out)), e.value);
                    checkOutput("voice_timeout", int'(vt), e.timeout);
                    checkOutput("ready_cycle", cyc, e.cycle);
                end
            end else if (vt) begin
                reportUnexpected("stray_voice_timeout", int'(vt));
            end
            if (ro) begin
                if (ov_q.size() == 0) reportUnexpected("unexpected_overrun", cyc);
                else                  checkOutput("overrun_cycle", cyc, ov_q.pop_front());
            end
        end
    end

    initial begin
        t_extra       = 0;
        t_junk        = 9999;
        t_random_junk = 1'b0;
        setVoices(3'b000, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_sample_out", int'(sample_out), 0);
        checkOutput("reset_ready", int'(nsr), 0);
        checkOutput("reset_timeout", int'(vt), 0);
        checkOutput("reset_overrun", int'(ro), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed mixes");
        setVoices(3'b111, 1000, 2000, -500, 2, 2, 2);
        applyStimulus();
        setVoices(3'b111, 32767, 32767, 32767, 0, 0, 0);
        applyStimulus();
        setVoices(3'b111, -32768, -32768, -32768, 1, 1, 1);
        applyStimulus();
        setVoices(3'b010, 0, 4000, 0, 0, 3, 0);
        applyStimulus();
        setVoices(3'b111, 600, 400, 0, 1, 2, -1);
        applyStimulus();
        setVoices(3'b111, 100, 200, 300, 3, 5, 4);
        t_extra = 2;
        applyStimulus();
        setVoices(3'b101, 7000, 0, -3000, 64, 0, 10);
        applyStimulus();

        $display("[TB] reset during collect");
        gen    = 1'b1;
        active = 3'b111;
        ready  = '0;
        @(posedge clk);
        #1;
        gen = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("midreset_sample_out", int'(sample_out), 0);
        checkOutput("midreset_ready", int'(nsr), 0);
        checkOutput("midreset_timeout", int'(vt), 0);
        checkOutput("midreset_overrun", int'(ro), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        setVoices(3'b011, -1234, 5678, 0, 1, 0, 0);
        applyStimulus();

        setVoices(3'b000, 111, 222, 333, 0, 0, 0);
        applyStimulus();

        $display("[TB] randomized mixes");
        t_random_junk = 1'b1;
        for (int n = 0; n < 30; n++) begin
            t_active = NV'($urandom);
            for (int k = 0; k < NV; k++) begin
                logic [SW-1:0] raw;
                raw         = SW'($urandom);
                t_sample[k] = int'($signed(raw));
                t_delay[k]  = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(0, 10));
            end
            t_extra = ($urandom_range(2) == 0) ? int'($urandom_range(1, 12)) : 0;
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
